// File: rtl/keypad_number_entry.sv
// Keypad number entry: conditions scanner key events, edits a BCD digit buffer,
// and converts it to binary on Enter, holding the result under a valid/ack handshake.
module keypad_number_entry #(
    parameter int MAX_DIGITS = 4,
    parameter int DATA_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_flag,
    input  logic [3:0]              key_code,
    input  logic                    rd_ack,
    output logic [DATA_W-1:0]       data_out,
    output logic                    data_valid,
    output logic [4*MAX_DIGITS-1:0] bcd_disp,
    output logic [2:0]              digit_cnt,
    output logic                    busy
);

    localparam int BUF_W = 4 * MAX_DIGITS;
    localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam logic [2:0]       MAX_CNT  = 3'(MAX_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_DIGITS - 1);

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        KEY_DOWN = 2'd1,
        CONVERT  = 2'd2,
        DONE     = 2'd3
    } state_t;

    // One Horner step: acc*10 + digit, multiply built from shifts.
    function automatic logic [DATA_W-1:0] mac10(input logic [DATA_W-1:0] acc,
                                                input logic [3:0]        digit);
        return (acc << 3) + (acc << 1) + DATA_W'(digit);
    endfunction

    logic [1:0]        flag_sync_r;
    logic [3:0]        code_meta_r;
    logic [3:0]        code_sync_r;
    logic              flag_prev_r;
    logic [3:0]        key_hold_r;
    state_t            state_r;
    logic [BUF_W-1:0]  bcd_r;
    logic [2:0]        cnt_r;
    logic [DATA_W-1:0] acc_r;
    logic [IDX_W-1:0]  idx_r;
    logic [DATA_W-1:0] data_out_r;
    logic              data_valid_r;
    logic              busy_r;

    logic              flag_s;
    logic              flag_rise_s;
    state_t            state_next_s;
    logic [BUF_W-1:0]  bcd_next_s;
    logic [2:0]        cnt_next_s;
    logic [DATA_W-1:0] acc_next_s;
    logic [IDX_W-1:0]  idx_next_s;
    logic [DATA_W-1:0] data_out_next_s;
    logic              data_valid_next_s;
    logic              busy_next_s;

    assign flag_s      = flag_sync_r[1];
    assign flag_rise_s = flag_s & ~flag_prev_r;

    // Two-stage synchronizers, rise-detect history and held key capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_sync_r <= 2'b00;
            code_meta_r <= 4'h0;
            code_sync_r <= 4'h0;
            flag_prev_r <= 1'b0;
            key_hold_r  <= 4'h0;
        end else begin
            flag_sync_r <= {flag_sync_r[0], key_flag};
            code_meta_r <= key_code;
            code_sync_r <= code_meta_r;
            flag_prev_r <= flag_s;
            if (flag_s) begin
                key_hold_r <= code_sync_r;
            end else begin
                key_hold_r <= key_hold_r;
            end
        end
    end

    // Next-state, buffer editing, conversion and handshake logic.
    always_comb begin
        state_next_s      = state_r;
        bcd_next_s        = bcd_r;
        cnt_next_s        = cnt_r;
        acc_next_s        = acc_r;
        idx_next_s        = idx_r;
        data_out_next_s   = data_out_r;
        data_valid_next_s = data_valid_r;

        case (state_r)
            ENTRY: begin
                // A rise is required, so a key still held after DONE never commits.
                if (flag_rise_s) begin
                    state_next_s = KEY_DOWN;
                end else begin
                    state_next_s = ENTRY;
                end
            end
            KEY_DOWN: begin
                if (!flag_s) begin
                    state_next_s = ENTRY;
                    if (key_hold_r <= 4'd9) begin
                        if (cnt_r < MAX_CNT) begin
                            bcd_next_s = (bcd_r << 4) | BUF_W'(key_hold_r);
                            cnt_next_s = cnt_r + 3'd1;
                        end else begin
                            bcd_next_s = bcd_r;
                        end
                    end else begin
                        case (key_hold_r)
                            KEY_ENTER: begin
                                if (cnt_r != 3'd0) begin
                                    acc_next_s   = {DATA_W{1'b0}};
                                    idx_next_s   = IDX_LAST;
                                    state_next_s = CONVERT;
                                end else begin
                                    state_next_s = ENTRY;
                                end
                            end
                            KEY_BKSP: begin
                                bcd_next_s = bcd_r >> 4;
                                if (cnt_r != 3'd0) begin
                                    cnt_next_s = cnt_r - 3'd1;
                                end else begin
                                    cnt_next_s = 3'd0;
                                end
                            end
                            KEY_CLEAR: begin
                                bcd_next_s = {BUF_W{1'b0}};
                                cnt_next_s = 3'd0;
                            end
                            default: begin
                                bcd_next_s = bcd_r;
                            end
                        endcase
                    end
                end else begin
                    state_next_s = KEY_DOWN;
                end
            end
            CONVERT: begin
                // Most significant digit first.
                acc_next_s = mac10(acc_r, bcd_r[4*idx_r +: 4]);
                if (idx_r == {IDX_W{1'b0}}) begin
                    data_out_next_s = acc_next_s;
                    state_next_s    = DONE;
                end else begin
                    idx_next_s = idx_r - 1'b1;
                end
            end
            DONE: begin
                data_valid_next_s = 1'b1;
                if (rd_ack && data_valid_r) begin
                    data_valid_next_s = 1'b0;
                    data_out_next_s   = {DATA_W{1'b0}};
                    bcd_next_s        = {BUF_W{1'b0}};
                    cnt_next_s        = 3'd0;
                    state_next_s      = ENTRY;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = ENTRY;
            end
        endcase

        busy_next_s = (state_next_s == CONVERT) || (state_next_s == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ENTRY;
            bcd_r        <= {BUF_W{1'b0}};
            cnt_r        <= 3'd0;
            acc_r        <= {DATA_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            data_out_r   <= {DATA_W{1'b0}};
            data_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            bcd_r        <= bcd_next_s;
            cnt_r        <= cnt_next_s;
            acc_r        <= acc_next_s;
            idx_r        <= idx_next_s;
            data_out_r   <= data_out_next_s;
            data_valid_r <= data_valid_next_s;
            busy_r       <= busy_next_s;
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign bcd_disp   = bcd_r;
    assign digit_cnt  = cnt_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_keypad_number_entry.sv
// Scoreboard bench for keypad_number_entry: directed keystrokes push expected
// results; a monitor pops and compares on each data_valid rise.
module tb_keypad_number_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_flag = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        rd_ack = 1'b0;
    logic [15:0] data_out;
    logic        data_valid;
    logic [15:0] bcd_disp;
    logic [2:0]  digit_cnt;
    logic        busy;

    keypad_number_entry #(.MAX_DIGITS(4), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_flag   (key_flag),
        .key_code   (key_code),
        .rd_ack     (rd_ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .bcd_disp   (bcd_disp),
        .digit_cnt  (digit_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] val;
        logic [15:0] bcd;
        logic [2:0]  cnt;
        int          at_cyc;
    } exp_t;
    exp_t sb[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compare each presented result with the scoreboard head.
    logic        dv_prev = 1'b0;
    logic [15:0] held_val = 16'h0;
    int          changes = 0;
    int          busy_cycles = 0;
    exp_t        e;
    always @(negedge clk) begin
        if (data_valid && !dv_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                check("data_out", 32'(data_out), 32'(e.val));
                check("bcd_at_valid", 32'(bcd_disp), 32'(e.bcd));
                check("cnt_at_valid", 32'(digit_cnt), 32'(e.cnt));
                check("valid_latency", 32'(cyc), 32'(e.at_cyc));
            end
            held_val = data_out;
            changes  = 0;
        end else if (data_valid && (data_out !== held_val)) begin
            changes++;
        end
        if (!data_valid && dv_prev) check("data_out_stable", 32'(changes), 32'(0));
        if (busy) busy_cycles++;
        dv_prev = data_valid;
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(logic [3:0] c, int hold, output int fall_cyc);
        key_code = c;
        tick(1);
        key_flag = 1'b1;
        tick(hold);
        key_flag = 1'b0;
        fall_cyc = cyc;
        tick(6);
    endtask

    task automatic tap(logic [3:0] c);
        int f;
        press(c, 4, f);
    endtask

    // Enter commits 3 clk after release; result valid 5 clk after that.
    task automatic enter_expect(logic [15:0] val, logic [15:0] bcd, logic [2:0] cnt);
        int f;
        exp_t x;
        press(4'hA, 4, f);
        x.val = val; x.bcd = bcd; x.cnt = cnt; x.at_cyc = f + 8;
        sb.push_back(x);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !data_valid; i++) tick(1);
        check("valid_timeout", 32'(data_valid), 32'(1));
    endtask

    task automatic ack_and_check();
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
        check("ack_valid", 32'(data_valid), 32'(0));
        check("ack_cnt", 32'(digit_cnt), 32'(0));
        check("ack_bcd", 32'(bcd_disp), 32'(0));
        check("ack_dout", 32'(data_out), 32'(0));
        check("ack_busy", 32'(busy), 32'(0));
        tick(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst = 1'b0;
        tick(3);
        check("rst_valid", 32'(data_valid), 32'(0));
        check("rst_dout", 32'(data_out), 32'(0));
        check("rst_bcd", 32'(bcd_disp), 32'(0));
        check("rst_cnt", 32'(digit_cnt), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst = 1'b1;
        tick(2);

        tap(4'd1); tap(4'd2); tap(4'd3); tap(4'd4);
        check("t1_bcd", 32'(bcd_disp), 32'h1234);
        check("t1_cnt", 32'(digit_cnt), 32'(4));
        enter_expect(16'd1234, 16'h1234, 3'd4);
        check("t1_busy", 32'(busy), 32'(1));
        wait_valid();
        ack_and_check();

        tap(4'd9); tap(4'd9); tap(4'd9); tap(4'd9); tap(4'd7);
        check("t2_bcd", 32'(bcd_disp), 32'h9999);
        check("t2_cnt", 32'(digit_cnt), 32'(4));
        enter_expect(16'd9999, 16'h9999, 3'd4);
        wait_valid();
        ack_and_check();

        tap(4'd5); tap(4'd6); tap(4'hB); tap(4'hB); tap(4'hB);
        check("t3_bksp_cnt", 32'(digit_cnt), 32'(0));
        check("t3_bksp_bcd", 32'(bcd_disp), 32'(0));
        tap(4'd0); tap(4'd7);
        check("t3_bcd", 32'(bcd_disp), 32'h0007);
        check("t3_cnt", 32'(digit_cnt), 32'(2));
        enter_expect(16'd7, 16'h0007, 3'd2);
        wait_valid();
        ack_and_check();

        b0 = busy_cycles;
        tap(4'hA); tap(4'd3); tap(4'hC); tap(4'hA); tap(4'hE);
        tick(10);
        check("t4_busy_never", 32'(busy_cycles - b0), 32'(0));
        check("t4_cnt", 32'(digit_cnt), 32'(0));
        check("t4_valid", 32'(data_valid), 32'(0));

        tap(4'd4); tap(4'd2);
        enter_expect(16'd42, 16'h0042, 3'd2);
        wait_valid();
        tick(100);
        tap(4'd8);
        check("t5_valid_held", 32'(data_valid), 32'(1));
        check("t5_dout_held", 32'(data_out), 32'(42));
        check("t5_bcd_kept", 32'(bcd_disp), 32'h0042);
        check("t5_cnt_kept", 32'(digit_cnt), 32'(2));
        ack_and_check();
        tick(10);
        check("t5_key8_dropped", 32'(digit_cnt), 32'(0));

        begin
            int f;
            press(4'd5, 2000, f);
        end
        check("t6_one_commit_cnt", 32'(digit_cnt), 32'(1));
        check("t6_one_commit_bcd", 32'(bcd_disp), 32'h0005);
        tap(4'hC);
        check("t6_clear", 32'(digit_cnt), 32'(0));

        tap(4'd1);
        tap(4'hA);
        check("t7_in_convert", 32'(busy), 32'(1));
        rst = 1'b0;
        #1;
        check("t7_rst_valid", 32'(data_valid), 32'(0));
        check("t7_rst_dout", 32'(data_out), 32'(0));
        check("t7_rst_bcd", 32'(bcd_disp), 32'(0));
        check("t7_rst_cnt", 32'(digit_cnt), 32'(0));
        check("t7_rst_busy", 32'(busy), 32'(0));
        tick(2);
        rst = 1'b1;
        tick(20);
        check("t7_no_result", 32'(data_valid), 32'(0));
        check("t7_idle_busy", 32'(busy), 32'(0));
        tap(4'd6);
        check("t7_entry_ok", 32'(bcd_disp), 32'h0006);

        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
